// File: rtl/ddc_iq_decim.sv
// IQ digital down-converter: NCO + mixers + CIC decimator per rail + 2-entry output FIFO.
// Optional macro DDC_ROUND_EN: round half up before the output shift instead of truncating.

module ddc_iq_rail #(
    parameter int ADC_W = 12,
    parameter int NCO_W = 12,
    parameter int CIC_N = 4,
    parameter int ACC_W = 48,
    parameter int OUT_W = 22
) (
    input  logic                    sys_clk,
    input  logic                    sys_rstn,
    input  logic                    flush,
    input  logic signed [ADC_W-1:0] samp,
    input  logic signed [NCO_W-1:0] coef,
    input  logic                    prod_en,
    input  logic                    int_en,
    input  logic                    comb_en,
    input  logic [5:0]              shift,
    output logic signed [OUT_W-1:0] result,
    output logic                    clip
);
    localparam int PROD_W = ADC_W + NCO_W;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  integ    [CIC_N];
    logic signed [ACC_W-1:0]  integ_nx [CIC_N];
    logic signed [ACC_W-1:0]  dly      [CIC_N];
    logic signed [ACC_W-1:0]  comb     [CIC_N+1];
    logic signed [ACC_W:0]    ext, rnd, shf;
    logic signed [OUT_W-1:0]  sat;
    logic                     clip_nx;

    // Integrators cascade within one update so the chain adds no extra sample delay.
    always_comb begin
        integ_nx[0] = integ[0] + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        for (int k = 1; k < CIC_N; k++)
            integ_nx[k] = integ[k] + integ_nx[k-1];
        comb[0] = integ[CIC_N-1];
        for (int k = 0; k < CIC_N; k++)
            comb[k+1] = comb[k] - dly[k];
        ext = {comb[CIC_N][ACC_W-1], comb[CIC_N]};
`ifdef DDC_ROUND_EN
        rnd = (shift == 6'd0) ? ext : ext + ((ACC_W+1)'(1) <<< (shift - 6'd1));
`else
        rnd = ext;
`endif
        shf     = rnd >>> shift;
        sat     = shf[OUT_W-1:0];
        clip_nx = 1'b0;
        if (shf > SAT_MAX) begin
            sat     = SAT_MAX[OUT_W-1:0];
            clip_nx = 1'b1;
        end else if (shf < SAT_MIN) begin
            sat     = SAT_MIN[OUT_W-1:0];
            clip_nx = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn || flush) begin
            prod   <= '0;
            result <= '0;
            clip   <= 1'b0;
            for (int k = 0; k < CIC_N; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
        end else begin
            if (prod_en) prod <= samp * coef;
            if (int_en)
                for (int k = 0; k < CIC_N; k++) integ[k] <= integ_nx[k];
            if (comb_en) begin
                for (int k = 0; k < CIC_N; k++) dly[k] <= comb[k];
                result <= sat;
                clip   <= clip_nx;
            end
        end
    end
endmodule

module ddc_iq_decim #(
    parameter int ADC_W   = 12,
    parameter int NCO_W   = 12,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int CIC_N   = 4,
    parameter int R_MAX   = 64,
    parameter int OUT_W   = 22
) (
    input  logic                      sys_clk,
    input  logic                      sys_rstn,
    input  logic [ADC_W-1:0]          s_adc_data_in,
    input  logic                      s_adc_valid,
    input  logic [PHASE_W-1:0]        cfg_phase_inc,
    input  logic [$clog2(R_MAX):0]    cfg_dec_ratio,
    input  logic [5:0]                cfg_out_shift,
    input  logic                      cfg_valid,
    output logic [2*OUT_W-1:0]        m_sample_data,
    output logic                      m_sample_valid,
    input  logic                      m_sample_ready,
    output logic                      m_overflow,
    output logic                      m_saturate
);
    localparam int RW    = $clog2(R_MAX) + 1;
    localparam int ACC_W = ADC_W + NCO_W + CIC_N * $clog2(R_MAX);
    localparam int WU_W  = $clog2(CIC_N + 1);

    logic signed [NCO_W-1:0]     lut [2**LUT_AW];
    logic [PHASE_W-1:0]          phase, phase_inc;
    logic [RW-1:0]               dec_ratio, r_eff, dec_cnt;
    logic [5:0]                  out_shift;
    logic [WU_W-1:0]             warm;
    logic [3:0]                  vld_pipe;
    logic signed [ADC_W-1:0]     samp;
    logic [1:0][NCO_W-1:0]       coef;
    logic [1:0][OUT_W-1:0]       res;
    logic [1:0]                  clip;
    logic [LUT_AW-1:0]           idx_i, idx_q;
    logic [1:0][2*OUT_W-1:0]     fifo_mem;
    logic                        wr_ptr, rd_ptr, push_ok, pop;
    logic [1:0]                  fifo_cnt;

    // Full-wave cosine ROM contents.
    initial begin
        real v;
        for (int k = 0; k < 2**LUT_AW; k++) begin
            v = real'(2**(NCO_W-1) - 1) * $cos(2.0 * 3.14159265358979323846 * k / (2.0 ** LUT_AW));
            lut[k] = NCO_W'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
        end
    end

    assign idx_i = phase[PHASE_W-1 -: LUT_AW];
    assign idx_q = idx_i - LUT_AW'(2**(LUT_AW-2));

    always_comb begin
        r_eff = dec_ratio;
        if (dec_ratio <= RW'(1))         r_eff = RW'(1);
        else if (dec_ratio > RW'(R_MAX)) r_eff = RW'(R_MAX);
    end

    for (genvar g = 0; g < 2; g++) begin : g_rail
        ddc_iq_rail #(.ADC_W(ADC_W), .NCO_W(NCO_W), .CIC_N(CIC_N), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_rail (
            .sys_clk (sys_clk),
            .sys_rstn(sys_rstn),
            .flush   (cfg_valid),
            .samp    (samp),
            .coef    (coef[g]),
            .prod_en (vld_pipe[0]),
            .int_en  (vld_pipe[1]),
            .comb_en (vld_pipe[2]),
            .shift   (out_shift),
            .result  (res[g]),
            .clip    (clip[g])
        );
    end

    assign m_sample_valid = (fifo_cnt != 2'd0);
    assign m_sample_data  = fifo_mem[rd_ptr];
    assign pop            = m_sample_valid && m_sample_ready;
    assign push_ok        = vld_pipe[3] && (fifo_cnt != 2'd2 || pop);

    // vld_pipe: [0] sample latched, [1] product ready, [2] decimation strobe, [3] result kept.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn || cfg_valid) begin
            phase_inc  <= sys_rstn ? cfg_phase_inc : '0;
            dec_ratio  <= sys_rstn ? cfg_dec_ratio : RW'(1);
            out_shift  <= sys_rstn ? cfg_out_shift : 6'd0;
            phase      <= '0;
            vld_pipe   <= '0;
            dec_cnt    <= '0;
            warm       <= WU_W'(CIC_N);
            samp       <= '0;
            coef       <= '0;
            fifo_mem   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
            m_overflow <= 1'b0;
            m_saturate <= 1'b0;
        end else begin
            vld_pipe[0] <= s_adc_valid;
            if (s_adc_valid) begin
                samp    <= {~s_adc_data_in[ADC_W-1], s_adc_data_in[ADC_W-2:0]};
                coef[0] <= lut[idx_i];
                coef[1] <= lut[idx_q];
                phase   <= phase + phase_inc;
            end
            vld_pipe[1] <= vld_pipe[0];
            vld_pipe[2] <= 1'b0;
            if (vld_pipe[1]) begin
                if (dec_cnt == r_eff - RW'(1)) begin
                    dec_cnt     <= '0;
                    vld_pipe[2] <= 1'b1;
                end else begin
                    dec_cnt <= dec_cnt + RW'(1);
                end
            end
            vld_pipe[3] <= 1'b0;
            if (vld_pipe[2]) begin
                if (warm != '0) warm <= warm - WU_W'(1);
                else            vld_pipe[3] <= 1'b1;
            end
            if (vld_pipe[3] && (|clip)) m_saturate <= 1'b1;
            if (vld_pipe[3] && !push_ok) m_overflow <= 1'b1;
            if (push_ok) begin
                fifo_mem[wr_ptr] <= {res[0], res[1]};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: ;
            endcase
        end
    end
endmodule
